// File: rtl/shift_add_mult_ctrl_if.sv
// Operand/result handshake plus the port pair to the external 3-bit adder.
// The slave side is the multiplier controller; the master side is its environment.
interface shift_add_mult_ctrl_if;
  logic       start;
  logic [2:0] A;
  logic [2:0] B;
  logic       busy;
  logic       done;
  logic [5:0] P;
  logic [2:0] ADD_A;
  logic [2:0] ADD_B;
  logic [2:0] ADD_S;
  logic       ADD_COUT;

  modport master (
    output start, A, B, ADD_S, ADD_COUT,
    input  busy, done, P, ADD_A, ADD_B
  );

  modport slave (
    input  start, A, B, ADD_S, ADD_COUT,
    output busy, done, P, ADD_A, ADD_B
  );
endinterface

// File: rtl/shift_add_mult_ctrl.sv
// 3x3 unsigned shift-and-add multiplier controller that steps an external ripple adder.
// Optional macro MULT_ZERO_BYPASS_EN: zero operands skip the iterations and finish in one cycle.
module shift_add_mult_ctrl (
  input  logic                   clk,
  input  logic                   rst_n,
  shift_add_mult_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [2:0] r_m;
  logic [2:0] r_q;
  logic [2:0] r_ph;
  logic [1:0] r_cnt;
  logic       r_busy;
  logic       r_done;
  logic       w_accept;
  logic       w_zero;

  // Next-state decode; a start is honoured only from IDLE or DONE
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_zero       = 1'b0;
`ifdef MULT_ZERO_BYPASS_EN
    w_zero       = (bus.A == 3'd0) || (bus.B == 3'd0);
`endif
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          w_accept     = 1'b1;
          w_next_state = w_zero ? ST_DONE : ST_RUN;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_cnt == 2'd2) begin
          w_next_state = ST_DONE;
        end else begin
          w_next_state = ST_RUN;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register with busy/done registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == ST_RUN);
      r_done  <= (w_next_state == ST_DONE);
    end
  end

  // Datapath: {cout,sum,Q} shifted right one place per iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m   <= 3'd0;
      r_q   <= 3'd0;
      r_ph  <= 3'd0;
      r_cnt <= 2'd0;
    end else if (w_accept) begin
      r_m   <= w_zero ? 3'd0 : bus.A;
      r_q   <= w_zero ? 3'd0 : bus.B;
      r_ph  <= 3'd0;
      r_cnt <= 2'd0;
    end else if (r_state == ST_RUN) begin
      r_ph  <= {bus.ADD_COUT, bus.ADD_S[2:1]};
      r_q   <= {bus.ADD_S[0], r_q[2:1]};
      r_cnt <= r_cnt + 2'd1;
    end
  end

  assign bus.ADD_A = r_ph;
  assign bus.ADD_B = r_q[0] ? r_m : 3'b000;
  assign bus.P     = {r_ph, r_q};
  assign bus.busy  = r_busy;
  assign bus.done  = r_done;

endmodule

// File: doc/shift_add_mult_ctrl.md
# shift_add_mult_ctrl

- Sequential controller for a 3x3 unsigned shift-and-add multiplier; produces a 6-bit product.
- Drives an external combinational 3-bit ripple adder through a dedicated port pair and steps it once per cycle for three iterations.
- Sits in the Multiplier block as the owner of the adder, between the operand source (start/A/B) and the product consumer (done/P).

## Interface

Parameters:
- None. Operand width is fixed at 3 bits to match the adder; the product is 6 bits.

Ports:
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request a multiply; sampled only when the block is ready
- A  in  3  multiplicand, captured when start is accepted
- B  in  3  multiplier, captured when start is accepted
- busy  out  1  high while iterations are in progress
- done  out  1  one-cycle pulse; P is valid from this cycle on
- P  out  6  product, held until the next accepted start
- ADD_A  out  3  adder operand A = partial-product high register PH
- ADD_B  out  3  adder operand B = M when Q[0]=1, else 3'b000
- ADD_S  in  3  adder sum, combinational from ADD_A and ADD_B
- ADD_COUT  in  1  adder carry-out

## Operation

Registers:
- M[2:0] multiplicand
- Q[2:0] multiplier / product low
- PH[2:0] product high
- CNT[1:0] iteration counter
- state

FSM states are IDLE, RUN and DONE. Reset places the FSM in IDLE.

IDLE:
- start=1 is accepted: M<=A, Q<=B, PH<=0, CNT<=0, go to RUN.
- start=0: stay in IDLE.

RUN, each cycle:
- PH <= {ADD_COUT, ADD_S[2:1]}.
- Q <= {ADD_S[0], Q[2:1]}.
- CNT <= CNT+1.
- When CNT==2, go to DONE after this edge.

DONE:
- done=1 for this cycle only.
- start=1 is accepted exactly as in IDLE, going directly to RUN. Otherwise go to IDLE.

Outputs and datapath rules:
- P = {PH, Q}. It is valid from DONE onward and stays unchanged in IDLE.
- Accepting a new start overwrites PH and Q, so P changes on that edge.
- start during RUN is ignored; A and B are not captured.
- ADD_A and ADD_B are driven in every state. Their values are consumed only in RUN.
- No overflow is possible: the maximum result is 7*7=49, which fits in 6 bits.
- ADD_COUT is always captured into PH[2].

Reset:
- rst_n low at any time, including mid-RUN, immediately clears state to IDLE and clears M, Q, PH and CNT.
- Result: busy=0, done=0, P=6'd0.
- Any partial result is discarded.

## Timing

- Reset values: busy=0, done=0, P=0, ADD_A=0, ADD_B=0.
- Latency from the start-accept edge (edge 0):
  - RUN during cycles 1-3, with busy=1.
  - done=1 in cycle 4.
  - Start-to-done is 4 clock edges.
- Throughput: one product every 4 cycles when start is held high (accepted back-to-back in DONE).
- busy is a registered decode of state==RUN. done is a registered decode of state==DONE.
- The adder path (PH/M/Q[0] -> ADD_S/ADD_COUT -> PH/Q) must close in one cycle.

## Configuration

Macro MULT_ZERO_BYPASS_EN.

Defined:
- If A==0 or B==0 when start is accepted, M, Q and PH are cleared and the FSM goes directly to DONE.
- done=1 in cycle 1 with P=0. busy stays 0.
- Non-zero operands behave as in the base design.

Undefined:
- All operands take the full 3-iteration RUN path; zero operands give P=0 in cycle 4.

## Test plan

1. A=7, B=7, one-cycle start.
   - busy=1 for cycles 1-3; done=1 in cycle 4 only; P=6'd49 (6'b110001), held through 5 idle cycles.
2. A=5, B=3, then A=2, B=6 with start held high.
   - P=15 at the first done.
   - Second operation accepted in the DONE cycle; P=12 at done 4 cycles later; no IDLE cycle between.
3. A=4, B=5 accepted; in cycle 2 drive start=1 with A=1, B=1.
   - Request ignored; P=20 at done; no second done follows.
4. A=6, B=7 accepted; rst_n low in cycle 2 (asynchronous, mid-cycle).
   - busy=0, done=0, P=0 immediately after assertion; after release, idle until the next start.
5. A=0, B=6.
   - With MULT_ZERO_BYPASS_EN: done in cycle 1, busy never high, P=0.
   - Without it: done in cycle 4, P=0.
6. Exhaustive sweep of all 64 (A,B) pairs through a combinational 3-bit adder model.
   - Every P equals A*B; done count equals 64.
